// File: rtl/ring_freq_counter.sv
// Ring-oscillator frequency counter: selects a tap, waits for settling, counts
// synchronised ring rising edges over a fixed clk gate window, reports the result.
module ring_freq_counter #(
   parameter int GATE_CYCLES   = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ring_in,
   input  logic             start,
   input  logic             sweep,
   input  logic [2:0]       tap_req,
   output logic [2:0]       tap,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic [2:0]       count_tap,
   output logic             count_valid,
   output logic             overflow
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SETTLE  = 2'd1;
   localparam logic [1:0] S_MEASURE = 2'd2;
   localparam logic [1:0] S_REPORT  = 2'd3;

   localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]             state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   ring_edge;
   logic [TW-1:0]          timer;
   logic [CNT_W-1:0]       edge_cnt;
   logic                   ovf;
   logic                   sweep_q;

   assign ring_edge = sync[SYNC_STAGES-1] & ~prev;
   // The final count_valid cycle still counts as busy, so a start there is dropped.
   assign busy = (state != S_IDLE) || count_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         sync        <= '0;
         prev        <= 1'b0;
         timer       <= '0;
         edge_cnt    <= '0;
         ovf         <= 1'b0;
         sweep_q     <= 1'b0;
         tap         <= 3'd0;
         count       <= '0;
         count_tap   <= 3'd0;
         count_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         sync        <= {sync[SYNC_STAGES-2:0], ring_in};
         prev        <= sync[SYNC_STAGES-1];
         count_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !count_valid) begin
                  sweep_q <= sweep;
                  tap     <= sweep ? 3'd0 : tap_req;
                  timer   <= TW'(SETTLE_CYCLES - 1);
                  state   <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (timer == '0) begin
                  timer    <= TW'(GATE_CYCLES - 1);
                  edge_cnt <= '0;
                  ovf      <= 1'b0;
                  state    <= S_MEASURE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_MEASURE: begin
               // An edge arriving at full scale is lost and flagged, never wrapped.
               if (ring_edge) begin
                  if (edge_cnt == CNT_MAX) ovf <= 1'b1;
                  else                     edge_cnt <= edge_cnt + 1'b1;
               end
               if (timer == '0) state <= S_REPORT;
               else             timer <= timer - 1'b1;
            end
            S_REPORT: begin
               count       <= edge_cnt;
               count_tap   <= tap;
               overflow    <= ovf;
               count_valid <= 1'b1;
               if (sweep_q && (tap != 3'd7)) begin
                  tap   <= tap + 3'd1;
                  timer <= TW'(SETTLE_CYCLES - 1);
                  state <= S_SETTLE;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ring_freq_counter.sv
// Directed and randomized bench for ring_freq_counter: the ring input is driven
// per clk cycle and recorded, and expected counts are derived from that record.
module tb_ring_freq_counter;

   localparam int G = 16;
   localparam int S = 4;
   localparam int HMAX = 8192;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ring_in = 1'b0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic       sweep = 1'b0;
   logic [2:0] tap_req = 3'd0;

   logic [2:0]  tap0, count_tap0, tap1, count_tap1;
   logic        busy0, count_valid0, overflow0, busy1, count_valid1, overflow1;
   logic [15:0] count0;
   logic [1:0]  count1;

   int   cyc = 0;
   bit   hist [0:HMAX-1];
   int   checks = 0;
   int   errors = 0;
   int   ring_mode = 0;   // 0 constant level, 1 periodic, 2 random per cycle
   int   ring_per = 4;
   logic ring_level = 1'b0;

   ring_freq_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .SYNC_STAGES(2), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start0), .sweep(sweep),
      .tap_req(tap_req), .tap(tap0), .busy(busy0), .count(count0), .count_tap(count_tap0),
      .count_valid(count_valid0), .overflow(overflow0));

   ring_freq_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .SYNC_STAGES(2), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start1), .sweep(sweep),
      .tap_req(tap_req), .tap(tap1), .busy(busy1), .count(count1), .count_tap(count_tap1),
      .count_valid(count_valid1), .overflow(overflow1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Value driven here is sampled by the DUT at posedge number cyc+1.
   always @(negedge clk) begin
      int  k;
      logic v;
      k = cyc + 1;
      case (ring_mode)
         1:       v = ((k % ring_per) < (ring_per / 2));
         2:       v = 1'($urandom_range(0, 1));
         default: v = ring_level;
      endcase
      ring_in = v;
      if (k < HMAX) hist[k] = v;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=%0d expected=finish", cyc);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Rising edges of the sampled ring during the gate window of a run that
   // entered SETTLE at posedge t (two sync stages delay each sample by one cycle).
   function automatic int model_edges(input int t);
      int n = 0;
      for (int j = t + S - 1; j <= t + S + G - 2; j++)
         if (hist[j] && !hist[j-1]) n++;
      return n;
   endfunction

   task automatic start_run(input bit which, input bit sw, input logic [2:0] tr, output int t);
      @(negedge clk);
      sweep   = sw;
      tap_req = tr;
      if (which) start1 = 1'b1;
      else       start0 = 1'b1;
      t = cyc + 1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      chk("busy_after_start", which ? busy1 : busy0, 1);
   endtask

   task automatic wait_valid(input bit which, input int exp_cyc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(which ? count_valid1 : count_valid0) && n < 200);
      chk("valid_cycle", cyc, exp_cyc);
   endtask

   task automatic check_run0(input int t, input logic [2:0] exp_tap, input bit last);
      wait_valid(0, t + S + G + 1);
      chk("count", count0, model_edges(t));
      chk("count_tap", count_tap0, exp_tap);
      chk("overflow", overflow0, 0);
      chk("busy_in_pulse", busy0, 1);
      if (last) begin
         @(negedge clk);
         chk("valid_drop", count_valid0, 0);
         chk("busy_drop", busy0, 0);
         chk("count_held", count0, model_edges(t));
      end
   endtask

   task automatic check_run1(input int t, input logic [2:0] exp_tap);
      int n;
      wait_valid(1, t + S + G + 1);
      n = model_edges(t);
      chk("sat_count", count1, (n > 3) ? 3 : n);
      chk("sat_overflow", overflow1, (n > 3) ? 1 : 0);
      chk("sat_tap", count_tap1, exp_tap);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_tap"}, tap0, 0);
      chk({tag, "_busy"}, busy0, 0);
      chk({tag, "_count"}, count0, 0);
      chk({tag, "_count_tap"}, count_tap0, 0);
      chk({tag, "_valid"}, count_valid0, 0);
      chk({tag, "_overflow"}, overflow0, 0);
      chk({tag, "_u1"}, {tap1, busy1, count1, count_tap1, count_valid1, overflow1}, 0);
   endtask

   initial begin
      int t, t2, pulses;
      logic [2:0] tr;

      // Reset
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // Single tap 3, ring period 4 -> 4 edges in the 16-cycle gate
      ring_mode = 1; ring_per = 4;
      start_run(0, 0, 3'd3, t);
      chk("tap_single", tap0, 3);
      check_run0(t, 3'd3, 1);
      chk("count_period4", count0, 4);

      // Sweep with ring period 8 -> 8 pulses of count 2, taps in order
      ring_per = 8;
      start_run(0, 1, 3'd5, t);
      chk("tap_sweep_first", tap0, 0);
      for (int i = 0; i < 8; i++) begin
         check_run0(t + i * (S + G + 1), 3'(i), i == 7);
         chk("count_period8", count0, 2);
      end

      // Sweep with random ring activity
      ring_mode = 2;
      start_run(0, 1, 3'($urandom_range(0, 7)), t);
      for (int i = 0; i < 8; i++) check_run0(t + i * (S + G + 1), 3'(i), i == 7);

      // Start during MEASURE is ignored
      start_run(0, 0, 3'd5, t);
      repeat (S + 3) @(negedge clk);
      sweep = 1'b1; tap_req = 3'd1; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("tap_unchanged", tap0, 5);
      check_run0(t, 3'd5, 1);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (count_valid0) pulses++;
      end
      chk("no_extra_pulse", pulses, 0);

      // Ring held high: no edges
      ring_mode = 0; ring_level = 1'b1;
      repeat (4) @(negedge clk);
      start_run(0, 0, 3'd6, t);
      check_run0(t, 3'd6, 1);
      chk("count_const1", count0, 0);

      // Single rising edge inside SETTLE only
      ring_level = 1'b0;
      repeat (4) @(negedge clk);
      start_run(0, 0, 3'd2, t);
      ring_level = 1'b1;
      check_run0(t, 3'd2, 1);
      chk("count_settle_edge", count0, 0);

      // Saturation on the narrow counter, then a clean run
      ring_mode = 1; ring_per = 4;
      start_run(1, 0, 3'd4, t);
      check_run1(t, 3'd4);
      chk("sat_expect_ovf", overflow1, 1);
      ring_mode = 0; ring_level = 1'b0;
      start_run(1, 0, 3'd1, t);
      check_run1(t, 3'd1);
      chk("after_sat_count", count1, 0);

      // Reset mid-MEASURE aborts without a pulse
      ring_mode = 2;
      start_run(0, 0, 3'd7, t);
      repeat (S + 5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_idle_outputs("midreset");
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (count_valid0) pulses++;
      end
      chk("abort_no_pulse", pulses, 0);

      // Random single-tap runs
      for (int i = 0; i < 5; i++) begin
         tr = 3'($urandom_range(0, 7));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         start_run(0, 0, tr, t2);
         chk("tap_rand", tap0, tr);
         check_run0(t2, tr, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
